// File: rtl/regfile_xfer_pkg.sv
// regfile_xfer_pkg: shared widths, register count and FSM state type for the register-file transfer engine.
package regfile_xfer_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;
  typedef enum logic [1:0] {IDLE, SAVE, DRAIN, RESTORE} xfer_state_e;
endpackage

// File: rtl/regfile_xfer_cksum.sv
// regfile_xfer_cksum: XOR accumulator over transferred words with a registered mismatch pulse.
module regfile_xfer_cksum
  import regfile_xfer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_chk,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_acc,
  output logic              o_err
);
  logic [DATA_W-1:0] r_acc;
  logic              r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      r_acc <= i_clr ? '0 : i_en ? r_acc ^ i_din : r_acc;
      r_err <= i_chk && (i_din != r_acc);
    end
  assign o_acc = r_acc;
  assign o_err = r_err;
endmodule

// File: rtl/regfile_xfer_engine.sv
// regfile_xfer_engine: bulk save/restore sequencer for the register file over valid/ready streams.
// Define RF_XFER_CKSUM_EN to append/verify an XOR checksum word on both streams.
module regfile_xfer_engine
  import regfile_xfer_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_save,
  input  logic              start_restore,
  output logic              busy,
  output logic              done,
  output logic              cksum_err,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_busa,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_busw,
  output logic              rf_wren,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);
  localparam logic [ADDR_W:0] P_NREGS = (ADDR_W+1)'(NUM_REGS);
`ifdef RF_XFER_CKSUM_EN
  localparam logic [ADDR_W:0] P_LAST = (ADDR_W+1)'(NUM_REGS);
`else
  localparam logic [ADDR_W:0] P_LAST = (ADDR_W+1)'(NUM_REGS - 1);
`endif
  xfer_state_e       r_state, w_state_nxt;
  logic [ADDR_W:0]   r_ptr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid, r_done;
  logic              w_load, w_accept, w_drain_hs, w_last, w_data_word;
  logic [DATA_W-1:0] w_acc;
  always_comb begin
    w_data_word = r_ptr < P_NREGS;
    w_last      = r_ptr == P_LAST;
    w_load      = (r_state == SAVE) && (!r_out_valid || out_ready);
    w_accept    = (r_state == RESTORE) && in_valid;
    w_drain_hs  = (r_state == DRAIN) && r_out_valid && out_ready;
    in_ready    = r_state == RESTORE;
    rf_wren     = w_accept && w_data_word;
    busy        = r_state != IDLE;
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = start_save ? SAVE : start_restore ? RESTORE : IDLE;
      SAVE:    w_state_nxt = (w_load && w_last) ? DRAIN : SAVE;
      DRAIN:   w_state_nxt = w_drain_hs ? IDLE : DRAIN;
      RESTORE: w_state_nxt = (w_accept && w_last) ? IDLE : RESTORE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= (r_state == IDLE) ? '0 : (w_load || w_accept) ? r_ptr + 1'b1 : r_ptr;
      r_done  <= w_drain_hs || (w_accept && w_last);
      if (w_load) begin
        r_out_data  <= w_data_word ? rf_busa : w_acc;
        r_out_valid <= 1'b1;
      end else if (w_drain_hs) begin
        r_out_valid <= 1'b0;
      end
    end
`ifdef RF_XFER_CKSUM_EN
  logic w_err;
  regfile_xfer_cksum #(.DATA_W(DATA_W)) u_cksum (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == IDLE),
    .i_en  ((w_load || w_accept) && w_data_word),
    .i_chk (w_accept && w_last),
    .i_din ((r_state == SAVE) ? rf_busa : in_data),
    .o_acc (w_acc),
    .o_err (w_err)
  );
  assign cksum_err = w_err;
`else
  assign w_acc     = '0;
  assign cksum_err = 1'b0;
`endif
  assign rf_ra     = r_ptr[ADDR_W-1:0];
  assign rf_rw     = r_ptr[ADDR_W-1:0];
  assign rf_busw   = in_data;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign done      = r_done;
endmodule

// File: tb/tb_regfile_xfer_engine.sv
// tb_regfile_xfer_engine: directed + randomized save/restore runs against a behavioural register-file model.
module tb_regfile_xfer_engine;
  localparam int NUM_REGS = 32;
`ifdef RF_XFER_CKSUM_EN
  localparam int NW = NUM_REGS + 1;
  localparam bit CK = 1'b1;
`else
  localparam int NW = NUM_REGS;
  localparam bit CK = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        start_save = 1'b0, start_restore = 1'b0;
  logic        busy, done, cksum_err, rf_wren, out_valid, in_ready;
  logic        out_ready = 1'b0, in_valid = 1'b0;
  logic [4:0]  rf_ra, rf_rw;
  logic [15:0] rf_busa, rf_busw, out_data, in_data = 16'h0;
  logic [15:0] rf [NUM_REGS];
  logic [15:0] tb_img [NUM_REGS];
  logic [15:0] mdl [NUM_REGS];
  logic        tb_load = 1'b0;
  int          wr_cnt = 0;
  int          checks = 0, errors = 0;

  regfile_xfer_engine dut (
    .clk(clk), .rst(rst), .start_save(start_save), .start_restore(start_restore),
    .busy(busy), .done(done), .cksum_err(cksum_err),
    .rf_ra(rf_ra), .rf_busa(rf_busa), .rf_rw(rf_rw), .rf_busw(rf_busw), .rf_wren(rf_wren),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  assign rf_busa = rf[rf_ra];
  always @(posedge clk)
    if (tb_load) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= tb_img[i];
    end else if (rf_wren) begin
      rf[rf_rw] <= rf_busw;
      wr_cnt    <= wr_cnt + 1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_img(input int mode);
    for (int i = 0; i < NUM_REGS; i++) begin
      tb_img[i] = mode == 0 ? 16'h1000 + 16'(i) : mode == 1 ? 16'($urandom) : 16'h0;
      mdl[i]    = tb_img[i];
    end
    @(negedge clk) tb_load = 1'b1;
    @(negedge clk) tb_load = 1'b0;
  endtask

  // mode: 0 ready held high, 1 ready toggling 1,0,1,0, 2 random ready
  task automatic run_save(input int mode, input bit both, input bit poke);
    logic [15:0] exp_q[$];
    logic [15:0] x, prev_d;
    bit          prev_stall;
    int          got, base, done_cyc, last_cyc;
    x = 16'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back(mdl[i]);
      x ^= mdl[i];
    end
    if (CK) exp_q.push_back(x);
    got = 0; done_cyc = -1; last_cyc = -1; prev_stall = 1'b0; prev_d = 16'h0;
    base = wr_cnt;
    @(negedge clk) begin start_save = 1'b1; start_restore = both; end
    @(negedge clk) begin start_save = 1'b0; start_restore = 1'b0; end
    for (int cyc = 1; cyc < 600 && done_cyc < 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      out_ready     = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 1) : 1'($urandom % 2);
      start_restore = poke && cyc == 5;
      if (prev_stall) chk("save_hold", {15'h0, out_valid, out_data}, {15'h0, 1'b1, prev_d});
      if (done) begin
        done_cyc = cyc;
        chk("save_done_valid_low", out_valid, 1'b0);
      end else if (out_valid && out_ready) begin
        chk("save_word", out_data, got < NW ? exp_q[got] : ~out_data);
        if (mode == 0) chk("save_timing", cyc, got + 2);
        got++;
        last_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
    end
    start_restore = 1'b0;
    out_ready     = 1'b0;
    chk("save_count", got, NW);
    chk("save_done_seen", done_cyc > 0, 1'b1);
    chk("save_done_after_last", done_cyc, last_cyc + 1);
    @(negedge clk);
    chk("save_done_pulse", done, 1'b0);
    chk("save_busy_after", busy, 1'b0);
    chk("save_no_writes", wr_cnt - base, 0);
  endtask

  // mode: 0 in_valid gapped every third cycle, 1 random valid and data
  task automatic run_restore(input int mode, input int rst_after, input bit bad_ck);
    logic [15:0] d [NW];
    logic [15:0] x;
    int          acc, base, done_cyc, last_cyc, dones;
    x = 16'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      d[i] = mode == 0 ? 16'hA000 + 16'(i) : 16'($urandom);
      x ^= d[i];
    end
    if (CK) d[NW-1] = bad_ck ? x ^ 16'h0001 : x;
    acc = 0; done_cyc = -1; last_cyc = -1;
    base = wr_cnt;
    @(negedge clk) start_restore = 1'b1;
    @(negedge clk) start_restore = 1'b0;
    for (int cyc = 1; cyc < 1000 && done_cyc < 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (rst_after >= 0 && acc == rst_after) begin
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wren", rf_wren, 1'b0);
        @(negedge clk) rst = 1'b0;
        dones = 0;
        repeat (4) @(negedge clk) dones += int'(done);
        chk("rst_no_done", dones, 0);
        chk("rst_idle", busy, 1'b0);
        break;
      end
      if (done) begin
        done_cyc = cyc;
        in_valid = 1'b0;
        chk("restore_cksum_err", cksum_err, CK && bad_ck);
        chk("restore_done_in_ready", in_ready, 1'b0);
      end else begin
        chk("restore_in_ready", in_ready, 1'b1);
        in_valid = mode == 0 ? (cyc % 3 != 0) : 1'($urandom % 2);
        in_data  = acc < NW ? d[acc] : 16'h0;
        #1;
        chk("restore_wren", rf_wren, in_valid && acc < NUM_REGS);
        if (in_valid && in_ready) begin
          if (acc < NUM_REGS) mdl[acc] = d[acc];
          acc++;
          last_cyc = cyc;
        end
      end
    end
    in_valid = 1'b0;
    if (rst_after < 0) begin
      chk("restore_accepts", acc, NW);
      chk("restore_done_after_last", done_cyc, last_cyc + 1);
      @(negedge clk);
      chk("restore_done_pulse", {done, cksum_err}, 2'b00);
      chk("restore_in_ready_after", in_ready, 1'b0);
      chk("restore_busy_after", busy, 1'b0);
    end
    chk("restore_writes", wr_cnt - base, rst_after < 0 ? NUM_REGS : rst_after);
    for (int i = 0; i < NUM_REGS; i++) chk("restore_reg", {11'h0, 5'(i), rf[i]}, {11'h0, 5'(i), mdl[i]});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_cksum_err", cksum_err, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 16'h0);
    chk("reset_wren", rf_wren, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    load_img(0);
    run_save(0, 1'b0, 1'b0);
    run_save(1, 1'b0, 1'b0);
    run_restore(0, -1, 1'b0);
    run_save(0, 1'b1, 1'b0);
    run_save(1, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      load_img(1);
      run_save(2, 1'b0, 1'b0);
      run_restore(1, -1, 1'b0);
      run_save(2, 1'b0, 1'b0);
    end
    load_img(2);
    run_restore(0, 10, 1'b0);
    if (CK) begin
      load_img(0);
      run_restore(0, -1, 1'b1);
      run_restore(1, -1, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
